// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps through a writable pattern table at a programmable rate
// in loop, ping-pong or one-shot order, driving polarity-adjusted registered LED pins.
module led_pattern_seq #(
    parameter int N_LED      = 8,
    parameter int DEPTH      = 16,
    parameter int PERIOD_W   = 28,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                osc_clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [AW-1:0]       last_idx,
    input  logic [PERIOD_W-1:0] period,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [N_LED-1:0]    wr_data,
    output logic [N_LED-1:0]    LED,
    output logic [AW-1:0]       step_idx,
    output logic                step_pulse,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN_UP   = 2'd1,
        S_RUN_DOWN = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [1:0]       MODE_PP   = 2'd1;
    localparam logic [1:0]       MODE_ONE  = 2'd2;
    localparam logic [N_LED-1:0] OFF       = {N_LED{ACTIVE_LOW}};
    localparam logic [AW-1:0]    LAST_MAX  = AW'(DEPTH - 1);
    localparam logic [AW:0]      DEPTH_X   = (AW + 1)'(DEPTH);

    state_t              r_state;
    logic [AW-1:0]       r_idx;
    logic [PERIOD_W-1:0] r_timer;
    logic [1:0]          r_mode;
    logic [AW-1:0]       r_last;
    logic [N_LED-1:0]    r_table [DEPTH];
    logic [N_LED-1:0]    r_led;
    logic                r_pulse;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [AW-1:0]       w_idx_nxt;
    logic [PERIOD_W-1:0] w_timer_nxt;
    logic [1:0]          w_mode_nxt;
    logic [AW-1:0]       w_last_nxt;
    logic                w_pulse_nxt;
    logic [PERIOD_W-1:0] w_period_m1;
    logic                w_running;
    logic                w_boundary;
    logic [AW-1:0]       w_last_clamped;

    // Period 0 behaves as period 1; a timer already past the limit fires at once.
    assign w_period_m1    = (period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}} : (period - PERIOD_W'(1));
    assign w_running      = en && ((r_state == S_RUN_UP) || (r_state == S_RUN_DOWN));
    assign w_boundary     = (r_timer >= w_period_m1);
    assign w_last_clamped = (last_idx > LAST_MAX) ? LAST_MAX : last_idx;

    // Next-state, index, timer and step-pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_mode_nxt  = r_mode;
        w_last_nxt  = r_last;
        w_pulse_nxt = 1'b0;
        if (start) begin
            w_state_nxt = S_RUN_UP;
            w_idx_nxt   = {AW{1'b0}};
            w_timer_nxt = {PERIOD_W{1'b0}};
            w_mode_nxt  = mode;
            w_last_nxt  = w_last_clamped;
        end else if (w_running && w_boundary) begin
            w_timer_nxt = {PERIOD_W{1'b0}};
            w_pulse_nxt = 1'b1;
            case (r_state)
                S_RUN_UP: begin
                    if (r_idx < r_last) begin
                        w_idx_nxt = r_idx + AW'(1);
                    end else begin
                        case (r_mode)
                            MODE_PP: begin
                                if (r_last == {AW{1'b0}}) begin
                                    w_idx_nxt = {AW{1'b0}};
                                end else begin
                                    w_state_nxt = S_RUN_DOWN;
                                    w_idx_nxt   = r_idx - AW'(1);
                                end
                            end
                            MODE_ONE: begin
                                // Index is held on the final pattern, so no step is signalled.
                                w_state_nxt = S_DONE;
                                w_pulse_nxt = 1'b0;
                            end
                            default: w_idx_nxt = {AW{1'b0}};
                        endcase
                    end
                end
                S_RUN_DOWN: begin
                    if (r_idx != {AW{1'b0}}) begin
                        w_idx_nxt = r_idx - AW'(1);
                    end else begin
                        w_state_nxt = S_RUN_UP;
                        w_idx_nxt   = AW'(1);
                    end
                end
                default: w_pulse_nxt = 1'b0;
            endcase
        end else if (w_running) begin
            w_timer_nxt = r_timer + PERIOD_W'(1);
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    // Sequencer state registers
    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= {AW{1'b0}};
            r_timer <= {PERIOD_W{1'b0}};
            r_mode  <= 2'd0;
            r_last  <= {AW{1'b0}};
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_timer <= w_timer_nxt;
            r_mode  <= w_mode_nxt;
            r_last  <= w_last_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= (w_state_nxt == S_RUN_UP) || (w_state_nxt == S_RUN_DOWN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Pattern table, host-writable in every state
    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= {N_LED{1'b0}};
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_X)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Pin drive: follows the current index one cycle later, refreshed every cycle
    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            r_led <= OFF;
        end else if (r_state == S_IDLE) begin
            r_led <= OFF;
        end else begin
            r_led <= r_table[r_idx] ^ OFF;
        end
    end

    assign LED        = r_led;
    assign step_idx   = r_idx;
    assign step_pulse = r_pulse;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed, table-driven bench for led_pattern_seq with default parameters (active-low LEDs).
module tb_led_pattern_seq;

    logic        osc_clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  last_idx;
    logic [27:0] period;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  LED;
    logic [3:0]  step_idx;
    logic        step_pulse;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        en;
        logic        st;
        logic [1:0]  md;
        logic [3:0]  ls;
        logic [27:0] pr;
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  led;
        logic [3:0]  idx;
        logic        pul;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t vq[$];

    led_pattern_seq dut (
        .osc_clk    (osc_clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .mode       (mode),
        .last_idx   (last_idx),
        .period     (period),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .LED        (LED),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic tick();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic s, input logic [1:0] m, input logic [3:0] l,
                       input logic [27:0] p, input logic we, input logic [3:0] wa, input logic [7:0] wd);
        en = e; start = s; mode = m; last_idx = l; period = p;
        wr_en = we; wr_addr = wa; wr_data = wd;
    endtask

    task automatic chk(input string nm, input logic [7:0] eled, input logic [3:0] eidx,
                       input logic ep, input logic eb, input logic ed);
        n_vec++;
        if (LED !== eled || step_idx !== eidx || step_pulse !== ep || busy !== eb || done !== ed) begin
            n_err++;
            $display("FAIL %s: got LED=%h idx=%0d pulse=%b busy=%b done=%b, want LED=%h idx=%0d pulse=%b busy=%b done=%b",
                     nm, LED, step_idx, step_pulse, busy, done, eled, eidx, ep, eb, ed);
        end
    endtask

    task automatic add(input logic e, input logic s, input logic [1:0] m, input logic [3:0] l,
                       input logic [27:0] p, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [7:0] led, input logic [3:0] idx, input logic pul,
                       input logic bsy, input logic dn);
        vec_t v;
        v.en = e; v.st = s; v.md = m; v.ls = l; v.pr = p; v.we = we; v.wa = wa; v.wd = wd;
        v.led = led; v.idx = idx; v.pul = pul; v.bsy = bsy; v.dn = dn;
        vq.push_back(v);
    endtask

    initial begin
        // Loop mode, period 3, patterns 01/02/04/08
        add(1'b0, 1'b0, 2'd0, 4'd3, 28'd3, 1'b1, 4'd0, 8'h01, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 4'd3, 28'd3, 1'b1, 4'd1, 8'h02, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 4'd3, 28'd3, 1'b1, 4'd2, 8'h04, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 2'd0, 4'd3, 28'd3, 1'b1, 4'd3, 8'h08, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFF, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd2, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd2, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd2, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hF7, 4'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hF7, 4'd3, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hF7, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd0, 4'd3, 28'd3, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        // Ping-pong, period 1: 0,1,2,3,2,1,0,1,2
        add(1'b1, 1'b1, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd2, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd3, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hF7, 4'd2, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd2, 1'b1, 1'b1, 1'b0);
        // One-shot, last 2, period 1; then a write to the displayed entry while DONE
        add(1'b1, 1'b1, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFD, 4'd2, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFB, 4'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b1, 4'd2, 8'hAA, 8'hFB, 4'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'h55, 4'd2, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'h55, 4'd0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 2'd2, 4'd2, 28'd1, 1'b0, 4'd0, 8'h00, 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);

        rst = 1'b1;
        drv(1'b0, 1'b0, 2'd0, 4'd0, 28'd1, 1'b0, 4'd0, 8'h00);
        repeat (2) @(posedge osc_clk);
        #1;
        chk("reset_held", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("reset_idle", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            drv(vq[i].en, vq[i].st, vq[i].md, vq[i].ls, vq[i].pr, vq[i].we, vq[i].wa, vq[i].wd);
            tick();
            chk($sformatf("vec%0d", i), vq[i].led, vq[i].idx, vq[i].pul, vq[i].bsy, vq[i].dn);
        end

        // Pause at timer=1, period 4: boundary on the third enabled edge after resuming
        drv(1'b1, 1'b1, 2'd0, 4'd3, 28'd4, 1'b0, 4'd0, 8'h00);
        tick();
        chk("pause_start", 8'hFD, 4'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk("pause_t1", 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("paused%0d", k), 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        end
        en = 1'b1;
        tick();
        chk("resume_a", 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("resume_b", 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("resume_bnd", 8'hFE, 4'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("resume_after", 8'hFD, 4'd1, 1'b0, 1'b1, 1'b0);

        // period 0, last_idx 0, loop: pulse every cycle, index stays 0
        drv(1'b1, 1'b1, 2'd0, 4'd0, 28'd0, 1'b0, 4'd0, 8'h00);
        tick();
        chk("p0_start", 8'hFD, 4'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("p0_hold%0d", k), 8'hFE, 4'd0, 1'b1, 1'b1, 1'b0);
        end
        start = 1'b1;
        tick();
        chk("start_vs_bnd", 8'hFE, 4'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk("p0_again", 8'hFE, 4'd0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-run clears outputs and the table
        drv(1'b1, 1'b0, 2'd1, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drv(1'b1, 1'b1, 2'd0, 4'd3, 28'd1, 1'b0, 4'd0, 8'h00);
        tick();
        chk("post_rst_start", 8'hFF, 4'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk("post_rst_tbl0", 8'hFF, 4'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_rst_tbl1", 8'hFF, 4'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_rst_tbl2", 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
